// File: rtl/load_store_unit.sv
// load_store_unit
//   Requester-side controller between the pipeline memory stage and the
//   data memory. Accepts one load/store at a time over a valid/ready
//   handshake and issues word-aligned memory cycles. Byte and halfword
//   stores are done as read-modify-write; loads are sign/zero extended.
//   Misaligned requests get an error response and never touch memory.
//
// Ports
//   i_clock, i_reset_n          clock, asynchronous active-low reset
//   i_req_valid / o_req_ready   request handshake (ready only in IDLE)
//   i_req_write                 1 = store, 0 = load
//   i_req_size                  00 byte, 01 half, 10/11 word
//   i_req_unsigned              load zero-extend (1) / sign-extend (0)
//   i_req_addr, i_req_wdata     byte address, right-justified store data
//   o_resp_valid                one-cycle response strobe
//   o_resp_rdata, o_resp_error  load data / misaligned flag
//   o_mem_address               word address, 0 when idle
//   o_mem_write, o_mem_data_write  single-cycle write strobe and data
//   o_mem_read, i_mem_read_data    read enable and returned word
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request
// READ     | load: memory read held for MEM_LATENCY cycles
// RMW_READ | sub-word store: read the old word before merging
// WRITE    | one-cycle memory write of the final word
// RESP     | one-cycle response to the requester

module load_store_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_error,
  output logic [31:0] o_mem_address,
  output logic        o_mem_write,
  output logic [31:0] o_mem_data_write,
  output logic        o_mem_read,
  input  logic [31:0] i_mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RMW_READ,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0] LAST_CNT = 2'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;   // store data; replaced by the merged word in RMW
  logic [31:0] r_rdata;
  logic        r_error;
  logic [1:0]  r_cnt;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_last;
  logic [4:0]  w_sh;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;
  logic [31:0] w_lane_mask;
  logic [31:0] w_merge;

  assign w_accept = i_req_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == LAST_CNT);

  always_comb begin
    case (i_req_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = i_req_addr[0];
      default: w_misaligned = (i_req_addr[1:0] != 2'b00);
    endcase
  end

  // Lane extraction for loads; the lane is shifted down to bit 0 first.
  assign w_sh      = {r_addr[1:0], 3'b000};
  assign w_shifted = i_mem_read_data >> w_sh;

  always_comb begin
    case (r_size)
      2'b00:   w_load_ext = {{24{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
      2'b01:   w_load_ext = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_ext = i_mem_read_data;
    endcase
  end

  // Sub-word store merge: only byte/half reach RMW_READ.
  assign w_lane_mask = (r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
  assign w_merge     = (i_mem_read_data & ~(w_lane_mask << w_sh)) |
                       ((r_wdata & w_lane_mask) << w_sh);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    o_req_ready      = 1'b0;
    o_resp_valid     = 1'b0;
    o_resp_rdata     = 32'h0;
    o_resp_error     = 1'b0;
    o_mem_address    = 32'h0;
    o_mem_write      = 1'b0;
    o_mem_data_write = 32'h0;
    o_mem_read       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (w_misaligned) begin
            w_next = S_RESP;
          end else if (!i_req_write) begin
            w_next = S_READ;
          end else if (i_req_size[1]) begin
            w_next = S_WRITE;
          end else begin
            w_next = S_RMW_READ;
          end
        end
      end
      S_READ: begin
        o_mem_read    = 1'b1;
        o_mem_address = {r_addr[31:2], 2'b00};
        if (w_last) w_next = S_RESP;
      end
      S_RMW_READ: begin
        o_mem_read    = 1'b1;
        o_mem_address = {r_addr[31:2], 2'b00};
        if (w_last) w_next = S_WRITE;
      end
      S_WRITE: begin
        o_mem_write      = 1'b1;
        o_mem_address    = {r_addr[31:2], 2'b00};
        o_mem_data_write = r_wdata;
        w_next           = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_rdata = r_rdata;
        o_resp_error = r_error;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_error    <= 1'b0;
      r_cnt      <= 2'd0;
    end else if (w_accept) begin
      r_write    <= i_req_write;
      r_size     <= i_req_size;
      r_unsigned <= i_req_unsigned;
      r_addr     <= i_req_addr;
      r_wdata    <= i_req_wdata;
      r_rdata    <= 32'h0;
      r_error    <= w_misaligned;
      r_cnt      <= 2'd0;
    end else if (r_state == S_READ || r_state == S_RMW_READ) begin
      if (w_last) begin
        r_cnt <= 2'd0;
        if (r_state == S_READ) begin
          r_rdata <= w_load_ext;
        end else begin
          r_wdata <= w_merge;
        end
      end else begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  // Latched direction is kept for observability of the captured request;
  // the state machine already encodes it.
  logic w_unused;
  assign w_unused = r_write;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Requester-side controller for the data memory interface. Accepts load/store requests from the pipeline's memory stage over a valid/ready handshake and issues word-aligned read/write cycles to the data memory. It supports byte, halfword and word accesses, using read-modify-write for sub-word stores and sign/zero extension for loads. Misaligned requests are rejected with an error response and perform no memory access.

## Interface
- MEM_LATENCY, 1, cycles from `mem_read` assertion to valid `mem_read_data`; legal range 1..4.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned request; valid with resp_valid
- mem_address  out  32  {addr[31:2], 2'b00}; 0 when not accessing
- mem_write  out  1  write strobe, exactly one cycle per store
- mem_data_write  out  32  full word to write
- mem_read  out  1  read enable, held for the read phase
- mem_read_data  in  32  word returned by memory

## Operation
- Byte lanes are little-endian: lane k = addr[1:0] occupies bits [8k+7:8k]. Halfword lane = addr[1] occupies bits [16·addr[1]+15 : 16·addr[1]].
- Request fields are latched on the accept edge (req_valid & req_ready). Request inputs are don't-care afterward.
- Misalignment: half with addr[0]=1; word (or size 11) with addr[1:0]≠0. Byte accesses are never misaligned.
- FSM states are IDLE, READ, RMW_READ, WRITE and RESP.
  - IDLE: req_ready=1. On accept:
    - misaligned -> RESP with error.
    - load -> READ.
    - word store -> WRITE.
    - byte/half store -> RMW_READ.
  - READ / RMW_READ: mem_read=1 and mem_address is driven. A 2-bit counter counts MEM_LATENCY cycles. On the final cycle's edge, mem_read_data is captured.
    - READ -> RESP. Rdata = selected lane, extended per req_unsigned.
    - RMW_READ -> WRITE. Merge word = captured word with the target lane replaced by req_wdata low bits.
  - WRITE: mem_write=1 for one cycle; mem_data_write = merge word, or req_wdata for word stores. -> RESP.
  - RESP: resp_valid=1 for one cycle. -> IDLE. There is no response backpressure; the consumer must sample it.
- Outside their active states, mem_read, mem_write, mem_address and mem_data_write are 0. resp_rdata and resp_error are 0 whenever resp_valid=0.
- mem_read and mem_write are never high in the same cycle.

## Timing
- Reset (reset=0) acts immediately, without waiting for a clock edge:
  - state goes to IDLE and the counter clears.
  - req_ready=1; all other outputs 0.
- Reset mid-operation abandons the access. A store whose mem_write edge has not yet occurred is not written.
- Latency is counted from accept edge E to the edge sampling resp_valid (L = MEM_LATENCY):
  - load: E+L+1.
  - word store: E+2, with memory written at E+1.
  - sub-word store: E+L+2, with memory written at E+L+1.
  - misaligned: E+1.
- Back-to-back: req_ready is low from E until the state returns to IDLE. The next accept is possible on the edge ending the RESP cycle +1, i.e. IDLE is always at least one cycle.
- Simultaneous events:
  - req_valid during a non-IDLE state is ignored and held by the requester.
  - req_valid held high across reset deassertion is accepted on the first edge after reset releases.

## Test plan
- Word store/load, MEM_LATENCY=1:
  - stimulus: store addr 0x0, wdata 500; then load addr 0x0.
  - required: mem_write for one cycle with mem_data_write=500; load resp_rdata=500 at E+2.
- Store overwrite: store 500 then 400 to 0x0; load -> 400.
- Byte store RMW:
  - stimulus: word 0x11223344 at 0x8; sb 0xAA to 0xA.
  - required: mem_data_write=0x11AA3344.
  - follow-up: lb 0xA returns 0xFFFFFFAA; lbu 0xA returns 0x000000AA.
- Halfword:
  - stimulus: sh 0x8001 to 0x6 over word 0x00000000.
  - required: write 0x80010000.
  - follow-up: lh 0x6 returns 0xFFFF8001; lhu returns 0x00008001.
- Misaligned:
  - stimulus: lw 0x2, then sh 0x3.
  - required for each: resp_valid with resp_error=1 and resp_rdata=0 at E+1; mem_read=mem_write=0 throughout.
- Latency and reset with MEM_LATENCY=3:
  - stimulus: lw.
  - required: response at E+4 with mem_read high for 3 cycles.
  - stimulus: assert reset during RMW_READ of an sb.
  - required: outputs drop immediately, no mem_write occurs, req_ready=1, and a subsequent load returns the unmodified word.
